// File: rtl/dct_pkg.sv
// Shared definitions for the 2D DCT datapath.
// Holds default widths, address-width derivation and the coefficient type.
package dct_pkg;

    localparam int DCT_DATA_W = 16;
    localparam int DCT_N      = 8;

    typedef logic [DCT_DATA_W-1:0] coef_t;

    // In-bank address width for an n x n block.
    function automatic int dct_addr_w(input int n);
        return 2 * $clog2(n);
    endfunction

endpackage

// File: rtl/dct_transpose_buffer_sdp_ram.sv
// Simple dual-port RAM with one write port and one registered read port.
// Ports: clk, wr_en/wr_addr/wr_data (write), rd_en/rd_addr/rd_data (read). No reset.
module sdp_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong transpose buffer: N x N blocks in row-major, out column-major.
// Ports: clk, rst; in_data/in_valid/in_ready; out_data/out_valid/out_ready/out_last.
module dct_transpose_buffer
    import dct_pkg::*;
#(
    parameter int DATA_W = DCT_DATA_W,
    parameter int N      = DCT_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int LOG2N  = $clog2(N);
    localparam int ADDR_W = dct_addr_w(N);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N * N - 1);

    logic              wb;
    logic              rb;
    logic [1:0]        full;
    logic [ADDR_W-1:0] wcnt;
    logic [ADDR_W-1:0] rcnt;
    logic              wr_en;
    logic              fetch;
    logic              loaded;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] ram_q;

    assign in_ready = !full[wb];
    assign wr_en    = in_valid && in_ready;
    assign fetch    = full[rb] && (!out_valid || out_ready);

    // Swapped halves make the linear read counter walk down columns.
    assign raddr = {rcnt[LOG2N-1:0], rcnt[ADDR_W-1:LOG2N]};

    // The RAM read register is the output register; it has no reset,
    // so it is masked to zero until the first fetch after reset.
    assign out_data = loaded ? ram_q : '0;

    sdp_ram #(
        .WIDTH (DATA_W),
        .DEPTH (2 * N * N),
        .AW    (ADDR_W + 1)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr ({wb, wcnt}),
        .wr_data (in_data),
        .rd_en   (fetch),
        .rd_addr ({rb, raddr}),
        .rd_data (ram_q)
    );

    // Set and clear of full[] always hit different banks in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb        <= 1'b0;
            rb        <= 1'b0;
            full      <= 2'b00;
            wcnt      <= '0;
            rcnt      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            loaded    <= 1'b0;
        end else begin
            if (wr_en) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt == LAST) begin
                    full[wb] <= 1'b1;
                    wb       <= ~wb;
                end
            end
            if (fetch) begin
                rcnt      <= rcnt + 1'b1;
                out_valid <= 1'b1;
                out_last  <= (rcnt == LAST);
                loaded    <= 1'b1;
                if (rcnt == LAST) begin
                    full[rb] <= 1'b0;
                    rb       <= ~rb;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Self-checking bench for dct_transpose_buffer at N=8/16b and N=4/12b.
// Reference model transposes captured blocks with plain array arithmetic.
module tb_dct_transpose_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [15:0] in_data8 = '0;
    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [15:0] out_data8;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic        out_last8;

    logic [11:0] in_data4 = '0;
    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [11:0] out_data4;
    logic        out_valid4;
    logic        out_ready4 = 1'b1;
    logic        out_last4;

    int checks = 0;
    int errors = 0;

    int blk8 [64];
    int w8 = 0;
    int exp8 [$];
    int nout8 = 0;
    int acc8 = 0;

    int blk4 [16];
    int w4 = 0;
    int exp4 [$];
    int nout4 = 0;

    always #5 clk = ~clk;

    dct_transpose_buffer #(.DATA_W(16), .N(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .out_data  (out_data8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_last  (out_last8)
    );

    dct_transpose_buffer #(.DATA_W(12), .N(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .out_data  (out_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_last  (out_last4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic spurious(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=unexpected output word expected=none", tag);
    endtask

    task automatic flush_model();
        w8 = 0; nout8 = 0; exp8.delete();
        w4 = 0; nout4 = 0; exp4.delete();
    endtask

    // Samples handshakes mid-cycle; both sides are stable until the next edge.
    task automatic mon();
        int e;
        if (rst) return;
        if (in_valid8 && in_ready8) begin
            blk8[w8] = int'(in_data8);
            w8++;
            acc8++;
            if (w8 == 64) begin
                for (int c = 0; c < 8; c++)
                    for (int r = 0; r < 8; r++)
                        exp8.push_back(blk8[r * 8 + c]);
                w8 = 0;
            end
        end
        if (out_valid8 && out_ready8) begin
            if (exp8.size() == 0) spurious("spur8");
            else begin
                e = exp8.pop_front();
                chk("data8", 32'(out_data8), 32'(e));
                chk("last8", 32'(out_last8), 32'(nout8 % 64 == 63));
                nout8++;
            end
        end
        if (!out_valid8) chk("idle_last8", 32'(out_last8), 32'd0);
        if (in_valid4 && in_ready4) begin
            blk4[w4] = int'(in_data4);
            w4++;
            if (w4 == 16) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        exp4.push_back(blk4[r * 4 + c]);
                w4 = 0;
            end
        end
        if (out_valid4 && out_ready4) begin
            if (exp4.size() == 0) spurious("spur4");
            else begin
                e = exp4.pop_front();
                chk("data4", 32'(out_data4), 32'(e));
                chk("last4", 32'(out_last4), 32'(nout4 % 16 == 15));
                nout4++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid8 = 1'b0; in_valid4 = 1'b0;
        out_ready8 = 1'b1; out_ready4 = 1'b1;
        while ((exp8.size() > 0 || exp4.size() > 0) && n < 2000) begin
            step();
            n++;
        end
        chk("drain_left", 32'(exp8.size() + exp4.size()), 32'd0);
        step();
        chk("drain_idle8", 32'(out_valid8), 32'd0);
        chk("drain_idle4", 32'(out_valid4), 32'd0);
    endtask

    initial begin
        int n;
        int base;

        // Power-on reset
        #1 rst = 1'b1;
        #2;
        chk("rst_in_ready", 32'(in_ready8), 32'd1);
        chk("rst_out_valid", 32'(out_valid8), 32'd0);
        chk("rst_out_last", 32'(out_last8), 32'd0);
        chk("rst_out_data", 32'(out_data8), 32'd0);
        chk("rst_out_data4", 32'(out_data4), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Single block 0..63
        for (int i = 0; i < 64; i++) begin
            in_data8 = 16'(i);
            in_valid8 = 1'b1;
            step();
        end
        chk("first_not_yet", 32'(out_valid8), 32'd0);
        in_valid8 = 1'b0;
        step();
        chk("first_valid", 32'(out_valid8), 32'd1);
        chk("first_word", 32'(out_data8), 32'd0);
        step();
        chk("second_word", 32'(out_data8), 32'd8);
        drain();

        // Back-to-back: 4 blocks, values 64b+i
        for (int i = 0; i < 256; i++) begin
            in_data8 = 16'(i);
            in_valid8 = 1'b1;
            step();
            chk("b2b_in_ready", 32'(in_ready8), 32'd1);
            if (i >= 64) chk("b2b_gap", 32'(out_valid8), 32'd1);
        end
        in_valid8 = 1'b0;
        n = 0;
        while (exp8.size() > 0 && n < 300) begin
            chk("b2b_tail_gap", 32'(out_valid8), 32'd1);
            step();
            n++;
        end
        drain();

        // Backpressure at output word 10
        for (int i = 0; i < 64; i++) begin
            in_data8 = 16'(i);
            in_valid8 = 1'b1;
            step();
        end
        in_valid8 = 1'b0;
        base = nout8;
        n = 0;
        while (nout8 - base < 10 && n < 200) begin
            step();
            n++;
        end
        out_ready8 = 1'b0;
        chk("bp_word", 32'(out_data8), 32'd17);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_data", 32'(out_data8), 32'd17);
            chk("bp_hold_valid", 32'(out_valid8), 32'd1);
        end
        drain();

        // Full stall: both banks fill while output is blocked
        out_ready8 = 1'b0;
        base = acc8;
        n = 0;
        while (acc8 - base < 128 && n < 400) begin
            in_data8 = 16'($urandom);
            in_valid8 = 1'b1;
            step();
            n++;
        end
        chk("stall_in_ready", 32'(in_ready8), 32'd0);
        for (int k = 0; k < 3; k++) begin
            in_data8 = 16'($urandom);
            step();
            chk("stall_hold", 32'(in_ready8), 32'd0);
        end
        chk("stall_no_accept", 32'(acc8 - base), 32'd128);
        out_ready8 = 1'b1;
        n = 0;
        while (!(out_valid8 && out_last8) && n < 200) begin
            chk("stall_wait", 32'(in_ready8), 32'd0);
            in_data8 = 16'($urandom);
            step();
            n++;
        end
        chk("stall_release", 32'(in_ready8), 32'd1);
        n = 0;
        while (acc8 - base < 192 && n < 400) begin
            in_data8 = 16'($urandom);
            in_valid8 = 1'b1;
            step();
            n++;
        end
        drain();

        // Reset mid-stream
        for (int k = 0; k < 100; k++) begin
            in_data8 = 16'($urandom);
            in_valid8 = 1'b1;
            out_ready8 = 1'($urandom_range(0, 1));
            in_data4 = 12'($urandom);
            in_valid4 = 1'b1;
            step();
        end
        rst = 1'b1;
        #1;
        flush_model();
        chk("mid_rst_in_ready", 32'(in_ready8), 32'd1);
        chk("mid_rst_valid", 32'(out_valid8), 32'd0);
        chk("mid_rst_last", 32'(out_last8), 32'd0);
        chk("mid_rst_data", 32'(out_data8), 32'd0);
        chk("mid_rst_valid4", 32'(out_valid4), 32'd0);
        in_valid8 = 1'b0; in_valid4 = 1'b0;
        out_ready8 = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(in_ready8), 32'd1);
        chk("post_rst_valid", 32'(out_valid8), 32'd0);
        for (int i = 0; i < 64; i++) begin
            in_data8 = 16'(1000 + 3 * i);
            in_valid8 = 1'b1;
            step();
        end
        drain();

        // N = 4, DATA_W = 12
        for (int i = 0; i < 16; i++) begin
            in_data4 = 12'(i);
            in_valid4 = 1'b1;
            step();
        end
        in_valid4 = 1'b0;
        step();
        chk("n4_w0", 32'(out_data4), 32'd0);
        step();
        chk("n4_w1", 32'(out_data4), 32'd4);
        step();
        chk("n4_w2", 32'(out_data4), 32'd8);
        step();
        chk("n4_w3", 32'(out_data4), 32'd12);
        step();
        chk("n4_w4", 32'(out_data4), 32'd1);
        drain();

        // Random soak on both instances
        for (int k = 0; k < 1500; k++) begin
            in_data8 = 16'($urandom);
            in_valid8 = ($urandom_range(0, 3) != 0);
            out_ready8 = ($urandom_range(0, 2) != 0);
            in_data4 = 12'($urandom);
            in_valid4 = ($urandom_range(0, 3) != 0);
            out_ready4 = ($urandom_range(0, 2) != 0);
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dct_transpose_buffer.md
# dct_transpose_buffer

Parametrised ping-pong transpose memory between the row 1D-DCT stage and the column 1D-DCT stage of the 2D DCT datapath. It accepts an N×N block of coefficients in row-major order and emits the same block in column-major order. Two banks let one block be written while the previous block is read. Both sides use valid/ready handshakes, and the buffer sustains one word per cycle on each side.

## Interface
- `DATA_W`, default 16: coefficient width.
- `N`, default 8: block dimension. Power of two, at least 2.
- `ADDR_W`, default 2·log2(N): in-bank address width. Derived; never overridden.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous reset, active-high.
- `in_data` input, DATA_W bits: row-major input word.
- `in_valid` input, 1 bit: input word present.
- `in_ready` output, 1 bit: buffer can accept a word.
- `out_data` output, DATA_W bits: column-major output word, registered.
- `out_valid` output, 1 bit: out_data holds a valid word.
- `out_ready` input, 1 bit: downstream accepts out_data.
- `out_last` output, 1 bit: out_data is the final word of a block.

## Operation
- Storage: 2 banks of N·N words. `wb` is the write-bank select and `rb` is the read-bank select; both are 1 bit. `full[1:0]` holds one flag per bank.
- Counters: `wcnt` and `rcnt`, each ADDR_W bits.
- Write side:
  - `in_ready = !full[wb]`, combinational from state only.
  - On `in_valid && in_ready`, write mem[wb][wcnt] and increment wcnt.
  - When wcnt = N·N−1: wcnt wraps to 0, set full[wb], toggle wb.
- Read side:
  - A fetch occurs when `full[rb] && (!out_valid || out_ready)`.
  - Fetch address: {rcnt[log2N−1:0], rcnt[ADDR_W−1:log2N]}. The halves are swapped, so rcnt steps down the columns.
  - On a fetch: out_data ← mem[rb][addr], out_valid ← 1, out_last ← (rcnt = N·N−1), and rcnt increments.
  - On the fetch at rcnt = N·N−1: rcnt wraps to 0, clear full[rb], toggle rb.
  - No fetch and `out_ready` high: out_valid ← 0, out_last ← 0. out_data holds its value.
  - `out_valid && !out_ready`: out_data, out_valid and out_last hold.
- Flag conflict cannot occur. Write sets full only on a bank whose flag is 0, and fetch clears full only on a bank whose flag is 1. The same-cycle set and clear therefore always target different banks, and both take effect.
- Both banks full: in_ready = 0 until the read side releases a bank.
- Reset values: wb = rb = 0, wcnt = rcnt = 0, full = 00, out_valid = 0, out_last = 0, out_data = 0. Memory contents are not reset and never cause X on out_data while out_valid = 0. in_ready reads 1 immediately after reset.
- Reset mid-block discards all partial and complete blocks.
- No tri-state outputs.

## Timing
- The final input word of a block accepted at rising edge k sets full at edge k. The first fetch happens at edge k+1, so out_valid is high from edge k+1.
- With out_ready held high, words of one block appear on N·N consecutive cycles.
- Consecutive blocks stream with no bubble when the input is continuous. Steady-state throughput is 1 word per cycle in and 1 word per cycle out.
- When out_ready is high in the same cycle as a fetch, the output register is replaced. No word is lost or duplicated.
- The input side stalls only when both banks are full.

## Structure
- Shared package `dct_pkg` holds:
  - `DCT_DATA_W` = 16 and `DCT_N` = 8 defaults.
  - the `clog2`-based ADDR_W derivation;
  - the `coef_t` typedef (logic [DCT_DATA_W−1:0]).
- Sub-module `sdp_ram`: simple dual-port memory with one write port and one read port, registered read, no reset.
  - Instantiated once with depth 2·N·N.
  - The bank bit is the address MSB.
- Control (flags, counters, output register) lives in the top module.

## Test plan
- Reset: assert rst mid-stream -> in_ready = 1, out_valid = 0, out_last = 0, out_data = 0. Deassert, then stream a fresh block -> output shows no residue from the earlier stream.
- Single block: N = 8, in_data = 0..63 on consecutive cycles, out_ready = 1 -> output is 0, 8, 16, …, 56, 1, 9, …, 63. First out_valid follows the edge after word 63. out_last is high only with 63.
- Back-to-back: 4 blocks, block b holds values 64b+i, continuous input and out_ready = 1 -> in_ready never drops, no output gaps, each block is correctly transposed.
- Backpressure: out_ready low for 5 cycles starting at output word 10 -> out_data holds value 17 (the 11th column-major word) and out_valid stays 1. On release the sequence resumes with no loss or duplicates.
- Full stall: out_ready = 0, feed 3 blocks -> in_ready = 0 after 128 accepted words. Then raise out_ready -> in_ready returns 1 the cycle after block 0's last fetch.
- Parameter sweep: N = 4 and DATA_W = 12 -> a 16-word block 0..15 reads out as 0, 4, 8, 12, 1, 5, ….
